// File: rtl/platform_utils_ccip_c1_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one CCI-P c1 TX port among N_REQ requesters.
// Optional protocol checking is enabled by defining PLATFORM_UTILS_CCIP_C1_ARB_CHECK_EN.

package platform_utils_ccip_c1_arbiter_pkg;

  localparam logic [3:0] C1_WRLINE_I = 4'h0;
  localparam logic [3:0] C1_WRLINE_M = 4'h1;
  localparam logic [3:0] C1_WRPUSH_I = 4'h2;
  localparam logic [3:0] C1_WRFENCE  = 4'h4;

  // cl_len encoding: 0 = 1 line, 1 = 2 lines, 3 = 4 lines, 2 is illegal
  typedef struct packed {
    logic [3:0]  req_type;
    logic [1:0]  cl_len;
    logic        sop;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [1:0]  cl_num;
    logic        format;
    logic        hit_miss;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

module platform_utils_ccip_c1_arbiter
  import platform_utils_ccip_c1_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  t_if_ccip_c1_Tx       req_c1Tx [N_REQ],
  output logic [N_REQ-1:0]     req_c1Accept,
  output t_if_ccip_c1_Rx       req_c1Rx [N_REQ],
  output t_if_ccip_c1_Tx       fiu_c1Tx,
  input  logic                 fiu_c1TxAlmFull,
  input  t_if_ccip_c1_Rx       fiu_c1Rx,
  output logic                 arb_error
);

  typedef enum logic {IDLE, LOCKED} t_state;

  t_state           state_reg, state_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
  logic [1:0]       beats_left_reg, beats_left_next;

  logic [N_REQ-1:0] req_valid;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             win_is_line;
  t_if_ccip_c1_Tx   tx_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_valid
    assign req_valid[gi] = req_c1Tx[gi].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      lock_idx_reg   <= '0;
      beats_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      lock_idx_reg   <= lock_idx_next;
      beats_left_reg <= beats_left_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    lock_idx_next   = lock_idx_reg;
    beats_left_next = beats_left_reg;
    win_valid       = 1'b0;
    win_idx         = '0;
    cand            = '0;
    win_is_line     = 1'b0;

    case (state_reg)
      IDLE: begin
        // Almost-full only gates packet starts; it never stalls a locked packet.
        if (!fiu_c1TxAlmFull) begin
          for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
            if (!win_valid && req_valid[cand[IDX_W-1:0]]) begin
              win_valid = 1'b1;
              win_idx   = cand[IDX_W-1:0];
            end
          end
        end
        if (win_valid) begin
          rr_ptr_next = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
          win_is_line = (req_c1Tx[win_idx].hdr.req_type == C1_WRLINE_I) ||
                        (req_c1Tx[win_idx].hdr.req_type == C1_WRLINE_M) ||
                        (req_c1Tx[win_idx].hdr.req_type == C1_WRPUSH_I);
          if (win_is_line && req_c1Tx[win_idx].hdr.sop &&
              (req_c1Tx[win_idx].hdr.cl_len != 2'd0)) begin
            state_next      = LOCKED;
            lock_idx_next   = win_idx;
            beats_left_next = req_c1Tx[win_idx].hdr.cl_len;
          end
        end
      end
      LOCKED: begin
        win_idx = lock_idx_reg;
        if (req_valid[lock_idx_reg]) begin
          win_valid       = 1'b1;
          beats_left_next = beats_left_reg - 2'd1;
          if (beats_left_reg == 2'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (reset) win_valid = 1'b0;

    tx_next                         = req_c1Tx[win_idx];
    tx_next.hdr.mdata[15 -: IDX_W]  = win_idx;
    tx_next.valid                   = win_valid;
    req_c1Accept                    = win_valid ? (N_REQ'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) fiu_c1Tx <= '0;
    else       fiu_c1Tx <= tx_next;
  end

  // Responses: header broadcast with tag stripped, rspValid only to the owner.
  logic [IDX_W-1:0] rsp_tag;
  logic             rsp_ok;
  t_if_ccip_c1_Rx   rsp_clean;

  assign rsp_tag = fiu_c1Rx.hdr.mdata[15 -: IDX_W];

  always_comb begin
    rsp_clean                          = fiu_c1Rx;
    rsp_clean.hdr.mdata[15 -: IDX_W]   = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        req_c1Rx[i] <= '0;
      end else begin
        req_c1Rx[i]          <= rsp_clean;
        req_c1Rx[i].rspValid <= fiu_c1Rx.rspValid && rsp_ok && (rsp_tag == IDX_W'(i));
      end
    end
  end

`ifdef PLATFORM_UTILS_CCIP_C1_ARB_CHECK_EN
  logic chk_hit;

  assign rsp_ok = (int'(rsp_tag) < N_REQ);

  always_comb begin
    chk_hit = 1'b0;
    if (win_valid) begin
      if (req_c1Tx[win_idx].hdr.sop && (req_c1Tx[win_idx].hdr.cl_len == 2'd2)) chk_hit = 1'b1;
      if ((state_reg == LOCKED) && req_c1Tx[win_idx].hdr.sop)                 chk_hit = 1'b1;
      if (req_c1Tx[win_idx].hdr.mdata[15 -: IDX_W] != '0)                     chk_hit = 1'b1;
    end
    if (fiu_c1Rx.rspValid && !rsp_ok) chk_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)        arb_error <= 1'b0;
    else if (chk_hit) arb_error <= 1'b1;
  end
`else
  assign rsp_ok    = 1'b1;
  assign arb_error = 1'b0;
`endif

endmodule

// File: tb/tb_platform_utils_ccip_c1_arbiter.sv
// Directed bench for platform_utils_ccip_c1_arbiter: round-robin order, packet lock,
// almost-full gating, response routing, reset mid-packet and the cl_len = 2 error flag.
module tb_platform_utils_ccip_c1_arbiter;
  import platform_utils_ccip_c1_arbiter_pkg::*;

  localparam int N = 4;
`ifdef PLATFORM_UTILS_CCIP_C1_ARB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk;
  logic           reset;
  t_if_ccip_c1_Tx req_tx [N];
  logic [N-1:0]   acc;
  t_if_ccip_c1_Rx req_rx [N];
  t_if_ccip_c1_Tx fiu_tx;
  logic           almfull;
  t_if_ccip_c1_Rx rx_in;
  logic           arb_error;

  int n_checks;
  int n_fail;

  platform_utils_ccip_c1_arbiter #(.N_REQ(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_c1Tx        (req_tx),
    .req_c1Accept    (acc),
    .req_c1Rx        (req_rx),
    .fiu_c1Tx        (fiu_tx),
    .fiu_c1TxAlmFull (almfull),
    .fiu_c1Rx        (rx_in),
    .arb_error       (arb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic t_if_ccip_c1_Tx mk(input logic [3:0] rt, input logic sop,
                                        input logic [1:0] len, input logic [15:0] md);
    t_if_ccip_c1_Tx t;
    t              = '0;
    t.hdr.req_type = rt;
    t.hdr.sop      = sop;
    t.hdr.cl_len   = len;
    t.hdr.address  = 42'(md);
    t.hdr.mdata    = md;
    t.data         = 512'(md);
    t.valid        = 1'b1;
    return t;
  endfunction

  function automatic logic [N-1:0] rx_valids();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = req_rx[k].rspValid;
    return v;
  endfunction

  logic [15:0] rr_tag_exp [N];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    almfull  = 1'b0;
    rx_in    = '0;
    for (int k = 0; k < N; k++) req_tx[k] = '0;
    rr_tag_exp[0] = 16'h0100;
    rr_tag_exp[1] = 16'h4101;
    rr_tag_exp[2] = 16'h8102;
    rr_tag_exp[3] = 16'hC103;

    tick();
    tick();
    // Reset state, with all requesters already presenting a single-line write
    for (int k = 0; k < N; k++) req_tx[k] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0100 + 16'(k));
    #1 chk("reset_accept", 64'(acc), 64'h0);
    tick();
    chk("reset_fiu_valid", 64'(fiu_tx.valid), 64'h0);
    chk("reset_rx_valid", 64'(rx_valids()), 64'h0);
    chk("reset_arb_error", 64'(arb_error), 64'h0);
    reset = 1'b0;

    // Round robin: grants 0,1,2,3 on consecutive cycles, tags one cycle later
    for (int k = 0; k < N; k++) begin
      #1 chk($sformatf("rr_grant%0d", k), 64'(acc), 64'(4'b0001 << k));
      tick();
      chk($sformatf("rr_fiu_valid%0d", k), 64'(fiu_tx.valid), 64'h1);
      chk($sformatf("rr_tag%0d", k), 64'(fiu_tx.hdr.mdata), 64'(rr_tag_exp[k]));
      req_tx[k].valid = 1'b0;
    end
    #1 chk("rr_idle_accept", 64'(acc), 64'h0);
    tick();
    chk("rr_idle_fiu", 64'(fiu_tx.valid), 64'h0);

    // Packet lock: requester 1 sends 4 beats while requester 2 waits
    req_tx[1] = mk(C1_WRLINE_I, 1'b1, 2'd3, 16'h0011);
    req_tx[2] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0022);
    for (int b = 0; b < 4; b++) begin
      #1 chk($sformatf("lock_beat%0d", b), 64'(acc), 64'b0010);
      tick();
      chk($sformatf("lock_tag%0d", b), 64'(fiu_tx.hdr.mdata), 64'h4011);
      if (b < 3) req_tx[1] = mk(C1_WRLINE_I, 1'b0, 2'd3, 16'h0011);
      else       req_tx[1].valid = 1'b0;
    end
    #1 chk("lock_release", 64'(acc), 64'b0100);
    tick();
    chk("lock_next_tag", 64'(fiu_tx.hdr.mdata), 64'h8022);
    req_tx[2].valid = 1'b0;

    // Almost full rises during beat 2 of a 4-beat packet from requester 0
    req_tx[0] = mk(C1_WRLINE_M, 1'b1, 2'd3, 16'h0033);
    req_tx[1] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0044);
    #1 chk("af_beat1", 64'(acc), 64'b0001);
    tick();
    almfull = 1'b1;
    req_tx[0].hdr.sop = 1'b0;
    chk("af_inflight", 64'(fiu_tx.valid), 64'h1);
    for (int b = 2; b <= 4; b++) begin
      #1 chk($sformatf("af_beat%0d", b), 64'(acc), 64'b0001);
      tick();
    end
    req_tx[0].valid = 1'b0;
    #1 chk("af_block0", 64'(acc), 64'h0);
    tick();
    #1 chk("af_block1", 64'(acc), 64'h0);
    tick();
    almfull = 1'b0;
    #1 chk("af_release", 64'(acc), 64'b0010);
    tick();
    chk("af_next_tag", 64'(fiu_tx.hdr.mdata), 64'h4044);
    req_tx[1].valid = 1'b0;

    // Response routing: tag 3 then tag 0
    rx_in                = '0;
    rx_in.hdr.resp_type  = 4'h1;
    rx_in.hdr.mdata      = 16'hC123;
    rx_in.rspValid       = 1'b1;
    tick();
    chk("rsp3_valid", 64'(rx_valids()), 64'b1000);
    chk("rsp3_mdata", 64'(req_rx[3].hdr.mdata), 64'h0123);
    rx_in.hdr.mdata  = 16'h0456;
    rx_in.hdr.format = 1'b1;
    rx_in.hdr.cl_num = 2'b01;
    tick();
    chk("rsp0_valid", 64'(rx_valids()), 64'b0001);
    chk("rsp0_mdata", 64'(req_rx[0].hdr.mdata), 64'h0456);
    chk("rsp0_format", 64'({req_rx[0].hdr.format, req_rx[0].hdr.cl_num}), 64'b101);
    rx_in.rspValid = 1'b0;
    tick();
    chk("rsp_idle", 64'(rx_valids()), 64'h0);

    // Reset after beat 2 of a 4-beat packet from requester 2
    req_tx[2] = mk(C1_WRLINE_I, 1'b1, 2'd3, 16'h0055);
    #1 chk("rst_beat1", 64'(acc), 64'b0100);
    tick();
    req_tx[2].hdr.sop = 1'b0;
    #1 chk("rst_beat2", 64'(acc), 64'b0100);
    tick();
    chk("rst_beat2_tag", 64'(fiu_tx.hdr.mdata), 64'h8055);
    reset = 1'b1;
    #1 chk("rst_accept", 64'(acc), 64'h0);
    tick();
    chk("rst_fiu_valid", 64'(fiu_tx.valid), 64'h0);
    reset = 1'b0;
    req_tx[0] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0066);
    req_tx[2] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0077);
    #1 chk("rst_rr_first", 64'(acc), 64'b0001);
    tick();
    chk("rst_rr_tag", 64'(fiu_tx.hdr.mdata), 64'h0066);
    req_tx[0].valid = 1'b0;
    #1 chk("rst_rr_second", 64'(acc), 64'b0100);
    tick();
    req_tx[2].valid = 1'b0;

    // A fence with nonzero cl_len is a single-beat packet
    req_tx[3] = mk(C1_WRFENCE, 1'b1, 2'd3, 16'h0088);
    req_tx[0] = mk(C1_WRLINE_I, 1'b1, 2'd0, 16'h0099);
    #1 chk("fence_grant", 64'(acc), 64'b1000);
    tick();
    req_tx[3].valid = 1'b0;
    #1 chk("fence_nolock", 64'(acc), 64'b0001);
    tick();
    req_tx[0].valid = 1'b0;

    // Illegal cl_len = 2 on a sop beat
    req_tx[1] = mk(C1_WRLINE_I, 1'b1, 2'd2, 16'h00AA);
    #1 chk("err_grant", 64'(acc), 64'b0010);
    tick();
    req_tx[1].valid = 1'b0;
    chk("err_set", 64'(arb_error), 64'(EXP_ERR));
    tick();
    chk("err_sticky", 64'(arb_error), 64'(EXP_ERR));
    reset = 1'b1;
    tick();
    chk("err_cleared", 64'(arb_error), 64'h0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
